// File: rtl/nv_nvdla_csb_master_falcon2csb_fifo_ctrl_pkg.sv
// Shared sizing constants for the falcon2csb request FIFO in the CSB master.
package nv_nvdla_csb_master_falcon2csb_fifo_ctrl_pkg;
  localparam int unsigned FALCON2CSB_FIFO_DEPTH = 4;
  localparam int unsigned FALCON2CSB_FIFO_AW    = 2;
  localparam int unsigned FALCON2CSB_PD_WIDTH   = 50;
endpackage

// File: rtl/nv_nvdla_csb_master_falcon2csb_fifo_ctrl.sv
// falcon2csb FIFO controller: pointers, occupancy counters and two-stage
// (latch, then commit) write timing for the external 4x50 flop RAM.
module nv_nvdla_csb_master_falcon2csb_fifo_ctrl
  import nv_nvdla_csb_master_falcon2csb_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = FALCON2CSB_FIFO_DEPTH,
  parameter int unsigned AW    = FALCON2CSB_FIFO_AW,
  parameter int unsigned WIDTH = FALCON2CSB_PD_WIDTH
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic             ram_iwe,
  output logic [WIDTH-1:0] ram_di,
  output logic             ram_we,
  output logic [AW-1:0]    ram_wa,
  output logic [AW-1:0]    ram_ra,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             ram_clk_en,
  output logic             fifo_idle
);

  logic [AW-1:0] wr_adr_q, wr_adr_d;
  logic [AW-1:0] rd_adr_q, rd_adr_d;
  logic [AW:0]   wr_count_q, wr_count_d;
  logic [AW:0]   rd_count_q, rd_count_d;
  logic          wr_pend_q;
  logic [AW-1:0] wr_pend_adr_q;
  logic          wr_push;
  logic          rd_pop;

  // Ready depends only on registered occupancy; a same-cycle pop does not free a slot early.
  assign wr_prdy = (wr_count_q != (AW+1)'(DEPTH));
  assign wr_push = wr_pvld & wr_prdy;
  assign rd_pvld = (rd_count_q != '0);
  assign rd_pop  = rd_pvld & rd_prdy;

  assign ram_iwe    = wr_push;
  assign ram_di     = wr_pd;
  assign ram_we     = wr_pend_q;
  assign ram_clk_en = wr_pend_q;
  assign ram_wa     = wr_pend_adr_q;
  assign ram_ra     = rd_adr_q;
  assign rd_pd      = ram_dout;
  assign fifo_idle  = (wr_count_q == '0) & ~wr_pend_q;

  always_comb begin
    wr_adr_d   = wr_push ? wr_adr_q + AW'(1) : wr_adr_q;
    rd_adr_d   = rd_pop  ? rd_adr_q + AW'(1) : rd_adr_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    unique case ({wr_push, rd_pop})
      2'b10:   wr_count_d = wr_count_q + (AW+1)'(1);
      2'b01:   wr_count_d = wr_count_q - (AW+1)'(1);
      default: wr_count_d = wr_count_q;
    endcase
    // rd_count tracks committed entries, so it lags a push by the pending write cycle.
    unique case ({wr_pend_q, rd_pop})
      2'b10:   rd_count_d = rd_count_q + (AW+1)'(1);
      2'b01:   rd_count_d = rd_count_q - (AW+1)'(1);
      default: rd_count_d = rd_count_q;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_adr_q      <= '0;
      rd_adr_q      <= '0;
      wr_count_q    <= '0;
      rd_count_q    <= '0;
      wr_pend_q     <= 1'b0;
      wr_pend_adr_q <= '0;
    end else begin
      wr_adr_q      <= wr_adr_d;
      rd_adr_q      <= rd_adr_d;
      wr_count_q    <= wr_count_d;
      rd_count_q    <= rd_count_d;
      wr_pend_q     <= wr_push;
      wr_pend_adr_q <= wr_adr_q;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_csb_master_falcon2csb_fifo_ctrl.sv
// Directed bench for the falcon2csb FIFO controller, with a behavioural
// latch-plus-array model of the flop RAM attached to the RAM pins.
module tb_nv_nvdla_csb_master_falcon2csb_fifo_ctrl;
  localparam int unsigned W = 50;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  logic [W-1:0]  wr_pd, rd_pd, ram_di, ram_dout;
  logic          ram_iwe, ram_we, ram_clk_en, fifo_idle;
  logic [1:0]    ram_wa, ram_ra;

  logic [W-1:0]  ram_latch;
  logic [W-1:0]  ram_mem [4];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] d  [4];
  logic [W-1:0] s  [10];
  logic [W-1:0] xtra, pa, pb;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_iwe) ram_latch <= ram_di;
    if (ram_we)  ram_mem[ram_wa] <= ram_latch;
  end
  assign ram_dout = ram_mem[ram_ra];

  nv_nvdla_csb_master_falcon2csb_fifo_ctrl #(.DEPTH(4), .AW(2), .WIDTH(50)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .ram_iwe        (ram_iwe),
    .ram_di         (ram_di),
    .ram_we         (ram_we),
    .ram_wa         (ram_wa),
    .ram_ra         (ram_ra),
    .ram_dout       (ram_dout),
    .ram_clk_en     (ram_clk_en),
    .fifo_idle      (fifo_idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and
  // outputs sampled 1 time unit later, well away from either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int unsigned i = 0; i < 4; i++)  d[i] = 50'h2_0000_0000_0A00 + 50'(i);
    for (int unsigned i = 0; i < 10; i++) s[i] = 50'h1_5555_0000_0000 + 50'(i * 17);
    xtra = 50'h0_ABCD_EF01_2345;
    pa   = 50'h3_0000_1111_2222;
    pb   = 50'h1_3333_4444_5555;

    rstn = 1'b0; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    #12;
    chk("rst_wr_prdy", wr_prdy, 1);
    chk("rst_rd_pvld", rd_pvld, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_clk_en", ram_clk_en, 0);
    chk("rst_ram_wa", ram_wa, 0);
    chk("rst_ram_ra", ram_ra, 0);
    chk("rst_idle", fifo_idle, 1);
    rstn = 1'b1;

    // Single push, 2-cycle latency to rd_pvld.
    tick();
    wr_pvld = 1'b1; wr_pd = 50'h3_FFFF_0000_1234; rd_prdy = 1'b1; #1;
    chk("t1_iwe", ram_iwe, 1);
    chk("t1_di", ram_di, 50'h3_FFFF_0000_1234);
    tick();
    wr_pvld = 1'b0; #1;
    chk("t1_we", ram_we, 1);
    chk("t1_clk_en", ram_clk_en, 1);
    chk("t1_wa", ram_wa, 0);
    chk("t1_pvld_c1", rd_pvld, 0);
    chk("t1_idle_c1", fifo_idle, 0);
    tick(); #1;
    chk("t1_pvld_c2", rd_pvld, 1);
    chk("t1_pd", rd_pd, 50'h3_FFFF_0000_1234);
    chk("t1_ra", ram_ra, 0);
    tick(); #1;
    chk("t1_pvld_c3", rd_pvld, 0);
    chk("t1_idle_c3", fifo_idle, 1);

    // Fill to full from address 1, then push against full while popping.
    rd_prdy = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      wr_pvld = 1'b1; wr_pd = d[k]; #1;
      chk("t2_prdy", wr_prdy, 1);
      chk("t2_iwe", ram_iwe, 1);
      tick();
    end
    wr_pd = 50'h0_DEAD_0000_BEEF; #1;
    chk("t2_full_prdy", wr_prdy, 0);
    chk("t2_full_iwe", ram_iwe, 0);
    chk("t2_last_wa", ram_wa, 0);
    tick();
    wr_pd = xtra; rd_prdy = 1'b1; #1;
    chk("t3_no_we", ram_we, 0);
    chk("t3_prdy", wr_prdy, 0);
    chk("t3_iwe", ram_iwe, 0);
    chk("t3_pd0", rd_pd, d[0]);
    chk("t3_ra0", ram_ra, 1);
    tick(); #1;
    chk("t3_prdy_next", wr_prdy, 1);
    chk("t3_iwe_next", ram_iwe, 1);
    chk("t3_pd1", rd_pd, d[1]);
    tick();
    wr_pvld = 1'b0; #1;
    chk("t3_pd2", rd_pd, d[2]);
    chk("t3_we", ram_we, 1);
    chk("t3_wa", ram_wa, 1);
    tick(); #1;
    chk("t3_pd3", rd_pd, d[3]);
    chk("t3_ra3", ram_ra, 0);
    tick(); #1;
    chk("t3_pvld_x", rd_pvld, 1);
    chk("t3_pd_x", rd_pd, xtra);
    chk("t3_ra_x", ram_ra, 1);
    tick(); #1;
    chk("t3_empty", rd_pvld, 0);
    chk("t3_idle", fifo_idle, 1);

    // Streaming 10 entries from address 2: pointers wrap 3->0.
    for (int unsigned k = 0; k < 12; k++) begin
      wr_pvld = (k < 10); wr_pd = (k < 10) ? s[k] : '0; rd_prdy = 1'b1; #1;
      if (k < 10) chk("t4_iwe", ram_iwe, 1);
      if (k >= 1 && k <= 10) begin
        chk("t4_we", ram_we, 1);
        chk("t4_wa", ram_wa, 64'((k + 1) % 4));
      end
      if (k >= 2) begin
        chk("t4_pvld", rd_pvld, 1);
        chk("t4_pd", rd_pd, s[k-2]);
        chk("t4_ra", ram_ra, 64'(k % 4));
      end
      tick();
    end
    wr_pvld = 1'b0; #1;
    chk("t4_drained", rd_pvld, 0);
    chk("t4_idle", fifo_idle, 1);

    // Reset while a write is pending.
    rd_prdy = 1'b0; wr_pvld = 1'b1; wr_pd = 50'h0_1111_2222_3333; #1;
    chk("t5_iwe", ram_iwe, 1);
    tick();
    wr_pvld = 1'b0; rstn = 1'b0; #1;
    chk("t5_we", ram_we, 0);
    chk("t5_clk_en", ram_clk_en, 0);
    chk("t5_wa", ram_wa, 0);
    chk("t5_idle_rst", fifo_idle, 1);
    tick();
    rstn = 1'b1;
    tick(); tick(); #1;
    chk("t5_pvld", rd_pvld, 0);
    chk("t5_prdy", wr_prdy, 1);
    chk("t5_idle", fifo_idle, 1);
    chk("t5_ra", ram_ra, 0);

    // Push and pop together with one committed entry and nothing pending.
    wr_pvld = 1'b1; wr_pd = pa; #1;
    tick();
    wr_pvld = 1'b0; #1;
    tick();
    wr_pvld = 1'b1; wr_pd = pb; rd_prdy = 1'b1; #1;
    chk("t6_pvld", rd_pvld, 1);
    chk("t6_pd_a", rd_pd, pa);
    chk("t6_iwe", ram_iwe, 1);
    tick();
    wr_pvld = 1'b0; #1;
    chk("t6_gap", rd_pvld, 0);
    chk("t6_prdy", wr_prdy, 1);
    chk("t6_not_idle", fifo_idle, 0);
    chk("t6_wa", ram_wa, 1);
    tick(); #1;
    chk("t6_back", rd_pvld, 1);
    chk("t6_pd_b", rd_pd, pb);
    chk("t6_ra", ram_ra, 1);
    tick(); #1;
    chk("t6_idle", fifo_idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
